// File: rtl/mux_scan_if.sv
// Control, ADC handshake and mux address bundle of the scan sequencer.
// master = sequencer side, slave = control logic / ADC capture side.
interface mux_scan_if;
  logic       start;
  logic       stop;
  logic       hold_en;
  logic [7:0] hold_ch;
  logic       adc_done;
  logic       adc_req;
  logic       F1_8ADD_A;
  logic       F1_8ADD_B;
  logic       F1_8ADD_C;
  logic       F2_8ADD_A;
  logic       F2_8ADD_B;
  logic       F2_8ADD_C;
  logic       F2_4ADD_A;
  logic       F2_4ADD_B;
  logic [7:0] ch_idx;
  logic       busy;
  logic       sample_vld;
  logic       timeout;
  logic       scan_done;

  modport master (
    input  start, stop, hold_en, hold_ch, adc_done,
    output adc_req,
    output F1_8ADD_A, F1_8ADD_B, F1_8ADD_C,
    output F2_8ADD_A, F2_8ADD_B, F2_8ADD_C,
    output F2_4ADD_A, F2_4ADD_B,
    output ch_idx, busy, sample_vld, timeout, scan_done
  );

  modport slave (
    output start, stop, hold_en, hold_ch, adc_done,
    input  adc_req,
    input  F1_8ADD_A, F1_8ADD_B, F1_8ADD_C,
    input  F2_8ADD_A, F2_8ADD_B, F2_8ADD_C,
    input  F2_4ADD_A, F2_4ADD_B,
    input  ch_idx, busy, sample_vld, timeout, scan_done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Three-level analog mux scan sequencer: address, settle, ADC handshake.
// Address pins come straight from the channel register, so they never glitch.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CH_LAST        = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  mux_scan_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    NEXT
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       CH_END    = 8'(CH_LAST);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ch_q, ch_d;
  logic             req_q, req_d;
  logic             vld_q, vld_d;
  logic             tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    req_d   = req_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    tmo_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          ch_d    = bus.hold_en ? bus.hold_ch : 8'd0;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          req_d   = 1'b1;
          cnt_d   = TMO_LD;
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CONVERT: begin
        // a stop here only takes effect once this conversion has ended
        if (bus.stop) pend_d = 1'b1;
        if (bus.adc_done) begin
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = NEXT;
        end else if (cnt_q == '0) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      NEXT: begin
        if (bus.stop || pend_q) begin
          state_d = IDLE;
        end else if (bus.hold_en && bus.hold_ch == ch_q) begin
          req_d   = 1'b1;
          cnt_d   = TMO_LD;
          state_d = CONVERT;
        end else if (bus.hold_en) begin
          ch_d    = bus.hold_ch;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else if (ch_q == CH_END) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + 8'd1;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) pend_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.adc_req    = req_q;
  assign bus.ch_idx     = ch_q;
  assign bus.busy       = busy_q;
  assign bus.sample_vld = vld_q;
  assign bus.timeout    = tmo_q;
  assign bus.scan_done  = done_q;

  assign bus.F1_8ADD_A = ch_q[0];
  assign bus.F1_8ADD_B = ch_q[1];
  assign bus.F1_8ADD_C = ch_q[2];
  assign bus.F2_8ADD_A = ch_q[3];
  assign bus.F2_8ADD_B = ch_q[4];
  assign bus.F2_8ADD_C = ch_q[5];
  assign bus.F2_4ADD_A = ch_q[6];
  assign bus.F2_4ADD_B = ch_q[7];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus queues expected pulses,
// a monitor pops them and also times settle, re-arm and request widths.
module tb_mux_scan_ctrl;
  localparam int S = 4;
  localparam int T = 8;
  localparam logic [1:0] K_VLD  = 2'd0;
  localparam logic [1:0] K_TMO  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] ch;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic kill = 1'b0;
  logic [7:0] kill_ch = 8'd0;
  logic [7:0] pin_v;
  ev_t exp_q[$];
  int vectors = 0;
  int errors = 0;

  mux_scan_if bus();

  mux_scan_ctrl #(
    .SETTLE_CYCLES(S),
    .TIMEOUT_CYCLES(T),
    .CH_LAST(255),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  assign pin_v = {bus.F2_4ADD_B, bus.F2_4ADD_A,
                  bus.F2_8ADD_C, bus.F2_8ADD_B, bus.F2_8ADD_A,
                  bus.F1_8ADD_C, bus.F1_8ADD_B, bus.F1_8ADD_A};

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input int ch);
    exp_q.push_back('{kind: k, ch: 8'(ch)});
  endtask

  task automatic expect_ev(input logic [1:0] k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: unexpected pulse at ch %0d, none queued",
               nm, bus.ch_idx);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 32'(k), 32'(e.kind));
      check({nm, "_ch"}, 32'(bus.ch_idx), 32'(e.ch));
      check({nm, "_pins"}, 32'(pin_v), 32'(e.ch));
    end
  endtask

  // ADC model: done three cycles after req, never for kill_ch
  initial begin
    int n;
    n = 0;
    bus.adc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.adc_req) n++;
      else n = 0;
      bus.adc_done = (n >= 3) && !(kill && bus.ch_idx == kill_ch);
    end
  end

  // monitor
  initial begin
    int cyc, mark, last_fall, rise_cyc, req_len;
    bit fresh;
    logic [7:0] pch;
    logic pbusy, preq;
    cyc = 0; mark = 0; last_fall = 0; rise_cyc = 0; req_len = 0;
    fresh = 1'b0; pch = 8'd0; pbusy = 1'b0; preq = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((bus.busy && !pbusy) || bus.ch_idx != pch) begin
        mark  = cyc;
        fresh = 1'b1;
      end
      if (bus.adc_req && !preq) begin
        if (fresh) check("settle_gap", 32'(cyc - mark), S);
        else check("rearm_gap", 32'(cyc - last_fall), 1);
        fresh    = 1'b0;
        rise_cyc = cyc;
      end
      if (!bus.adc_req && preq) begin
        last_fall = cyc;
        req_len   = cyc - rise_cyc;
      end
      if (bus.sample_vld) begin
        expect_ev(K_VLD, "vld");
        check("vld_req_len", 32'(req_len), 3);
        if (bus.ch_idx == 8'hB5) begin
          check("b5_f1", 32'({bus.F1_8ADD_C, bus.F1_8ADD_B, bus.F1_8ADD_A}), 32'b101);
          check("b5_f2_8", 32'({bus.F2_8ADD_C, bus.F2_8ADD_B, bus.F2_8ADD_A}), 32'b110);
          check("b5_f2_4", 32'({bus.F2_4ADD_B, bus.F2_4ADD_A}), 32'b10);
        end
      end
      if (bus.timeout) begin
        expect_ev(K_TMO, "tmo");
        check("tmo_req_len", 32'(req_len), T);
      end
      if (bus.scan_done) expect_ev(K_DONE, "done");
      pch   = bus.ch_idx;
      pbusy = bus.busy;
      preq  = bus.adc_req;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_ch(input logic [7:0] ch, input logic req,
                         input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy && bus.ch_idx == ch && bus.adc_req == req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL %s: wait expired, ch_idx %0d want %0d", nm, bus.ch_idx, ch);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL %s: busy still 1, want 0", nm);
    end
  endtask

  task automatic wait_vld(input int n, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < 1000 && seen < n; i++) begin
      @(negedge clk);
      if (bus.sample_vld) seen++;
    end
    if (seen < n) begin
      vectors++;
      errors++;
      $display("FAIL %s: saw %0d sample_vld, want %0d", nm, seen, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.hold_en = 1'b0;
    bus.hold_ch = 8'd0;
    cycles(200);
    check("rst_req", 32'(bus.adc_req), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ch", 32'(bus.ch_idx), 0);
    check("rst_pins", 32'(pin_v), 0);
    check("rst_pulses", 32'({bus.sample_vld, bus.timeout, bus.scan_done}), 0);
    reset = 1'b0;
    cycles(2);

    // full scan
    for (int c = 0; c < 256; c++) push(K_VLD, c);
    push(K_DONE, 255);
    pulse_start();
    wait_idle("scan_idle");
    cycles(2);
    check("scan_end_ch", 32'(bus.ch_idx), 255);
    check("scan_end_pins", 32'(pin_v), 32'hFF);
    check("scan_q_empty", 32'(exp_q.size()), 0);

    // timeout on ch 3, then stop while converting ch 6
    kill = 1'b1;
    kill_ch = 8'd3;
    for (int c = 0; c < 3; c++) push(K_VLD, c);
    push(K_TMO, 3);
    for (int c = 4; c < 7; c++) push(K_VLD, c);
    pulse_start();
    wait_ch(8'd6, 1'b1, "tmo_wait_ch6");
    pulse_stop();
    wait_idle("tmo_idle");
    cycles(2);
    kill = 1'b0;
    check("tmo_q_empty", 32'(exp_q.size()), 0);

    // stop during settle of ch 10
    for (int c = 0; c < 10; c++) push(K_VLD, c);
    pulse_start();
    wait_ch(8'd10, 1'b0, "settle_wait_ch10");
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_settle_busy", 32'(bus.busy), 0);
    cycles(10);
    check("stop_settle_req", 32'(bus.adc_req), 0);
    check("stop_settle_ch", 32'(bus.ch_idx), 10);
    check("stop_settle_q", 32'(exp_q.size()), 0);

    // stop during convert of ch 12
    for (int c = 0; c < 13; c++) push(K_VLD, c);
    pulse_start();
    wait_ch(8'd12, 1'b1, "conv_wait_ch12");
    pulse_stop();
    wait_idle("stop_conv_idle");
    cycles(4);
    check("stop_conv_ch", 32'(bus.ch_idx), 12);
    check("stop_conv_q", 32'(exp_q.size()), 0);

    // hold on ch 37, then move to 40
    bus.hold_en = 1'b1;
    bus.hold_ch = 8'd37;
    for (int i = 0; i < 3; i++) push(K_VLD, 37);
    pulse_start();
    wait_vld(3, "hold37");
    bus.hold_ch = 8'd40;
    for (int i = 0; i < 2; i++) push(K_VLD, 40);
    wait_vld(2, "hold40");
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("hold_stop_busy", 32'(bus.busy), 0);
    check("hold_stop_ch", 32'(bus.ch_idx), 40);
    bus.hold_en = 1'b0;
    cycles(2);
    check("hold_q", 32'(exp_q.size()), 0);

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check("start_stop_busy", 32'(bus.busy), 0);
    cycles(3);
    check("start_stop_busy2", 32'(bus.busy), 0);

    // start while busy is ignored; async reset mid-conversion
    for (int c = 0; c < 4; c++) push(K_VLD, c);
    pulse_start();
    wait_ch(8'd2, 1'b0, "busy_wait_ch2");
    pulse_start();
    wait_ch(8'd4, 1'b1, "rst_wait_ch4");
    #2;
    reset = 1'b1;
    #1;
    check("async_req", 32'(bus.adc_req), 0);
    check("async_ch", 32'(bus.ch_idx), 0);
    check("async_busy", 32'(bus.busy), 0);
    cycles(3);
    reset = 1'b0;
    cycles(3);
    check("async_q", 32'(exp_q.size()), 0);
    check("async_stay_idle", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
